// File: rtl/ff_fifo_pkg.sv
// Shared helpers for ff_fifo_with_levels: pointer/count width functions,
// the status-flag bundle and its derivation, and the legality check for the
// level parameters used at elaboration time.
package ff_fifo_pkg;

  // Status flags as one registered bundle
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{empty: 1'b1, full: 1'b0,
                                         almost_empty: 1'b1, almost_full: 1'b0};

  // Bits needed to address depth entries (0..depth-1)
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Bits needed to hold an occupancy of 0..depth
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // True when the geometry and threshold parameters are usable
  function automatic bit params_ok(input int width, input int depth,
                                   input int af_level, input int ae_level);
    return (width >= 1) && (depth >= 2) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

  // Flags implied by an occupancy value
  function automatic fifo_flags_t calc_flags(input int cnt, input int depth,
                                             input int af_level, input int ae_level);
    fifo_flags_t f;
    f.empty        = (cnt == 0);
    f.full         = (cnt == depth);
    f.almost_empty = (cnt <= ae_level);
    f.almost_full  = (cnt >= af_level);
    return f;
  endfunction

endpackage

// File: rtl/ff_fifo_wrap_ptr.sv
// Wrapping index counter: advances by one on inc and returns to 0 after
// depth-1, so it works for any depth, not only powers of two.
module ff_fifo_wrap_ptr
  import ff_fifo_pkg::*;
#(
  parameter int depth = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  output logic [ptr_w(depth)-1:0] ptr
);

  localparam int PW = ptr_w(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;

  // Next index, folding back to zero past the last entry
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (inc) begin
      if (r_ptr == LAST) w_ptr_nxt = '0;
      else               w_ptr_nxt = r_ptr + PW'(1);
    end
  end

  // Pointer register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_ptr_nxt;
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/ff_fifo_with_levels.sv
// Synchronous first-word-fall-through FIFO with registered occupancy and
// empty/full/almost-empty/almost-full flags.
// Optional feature: define FF_FIFO_WITH_LEVELS_ERR_EN to build sticky
// overflow/underflow detection; otherwise both outputs are constant 0.
module ff_fifo_with_levels
  import ff_fifo_pkg::*;
#(
  parameter int width              = 8,
  parameter int depth              = 10,
  parameter int almost_full_level  = 8,
  parameter int almost_empty_level = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [width-1:0]        write_data,
  output logic [width-1:0]        read_data,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [cnt_w(depth)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);

  if (!params_ok(width, depth, almost_full_level, almost_empty_level)) begin : g_bad_params
    $fatal(1, "ff_fifo_with_levels: illegal width/depth/level parameters");
  end

  logic [width-1:0] r_mem [depth];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  fifo_flags_t      r_flags;
  fifo_flags_t      w_flags_nxt;
  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  logic             w_push_acc;
  logic             w_pop_acc;

  // A push into a full FIFO is still taken when a pop frees the slot in the
  // same cycle; a pop from an empty FIFO is never taken (no bypass path).
  assign w_push_acc = push & (~r_flags.full | pop);
  assign w_pop_acc  = pop & ~r_flags.empty;

  ff_fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_push_acc),
    .ptr   (w_wr_ptr)
  );

  ff_fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pop_acc),
    .ptr   (w_rd_ptr)
  );

  // Storage write; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[w_wr_ptr] <= write_data;
  end

  // Head entry is visible without a read cycle
  assign read_data = r_mem[w_rd_ptr];

  // Next occupancy: simultaneous push and pop cancel out
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_acc && !w_pop_acc)      w_count_nxt = r_count + CW'(1);
    else if (w_pop_acc && !w_push_acc) w_count_nxt = r_count - CW'(1);
  end

  // Flags derived from the next occupancy so they line up with count
  always_comb begin
    w_flags_nxt = calc_flags(int'(w_count_nxt), depth,
                             almost_full_level, almost_empty_level);
  end

  // Occupancy and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_flags <= FLAGS_RESET;
    end else begin
      r_count <= w_count_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  assign count        = r_count;
  assign empty        = r_flags.empty;
  assign full         = r_flags.full;
  assign almost_empty = r_flags.almost_empty;
  assign almost_full  = r_flags.almost_full;

`ifdef FF_FIFO_WITH_LEVELS_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error capture: a push dropped while full, a pop seen while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && r_flags.full && !pop) r_overflow  <= 1'b1;
      if (pop && r_flags.empty)         r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ff_fifo_with_levels.sv
// Randomised and directed bench for ff_fifo_with_levels (8 bits, 10 deep,
// levels 8/2) against a queue-based reference model.
module tb_ff_fifo_with_levels;

  localparam int W     = 8;
  localparam int DEPTH = 10;
  localparam int AFL   = 8;
  localparam int AEL   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic          pop;
  logic [W-1:0]  wd;
  logic [W-1:0]  read_data;
  logic          empty, full, almost_empty, almost_full;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  logic m_ov = 1'b0;
  logic m_un = 1'b0;

`ifdef FF_FIFO_WITH_LEVELS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  ff_fifo_with_levels #(
    .width(W), .depth(DEPTH),
    .almost_full_level(AFL), .almost_empty_level(AEL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .write_data   (wd),
    .read_data    (read_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated with the acceptance rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ov <= 1'b0;
      m_un <= 1'b0;
    end else begin
      if (ERR_EN && push && q.size() == DEPTH && !pop) m_ov <= 1'b1;
      if (ERR_EN && pop && q.size() == 0)              m_un <= 1'b1;
      if (push && (q.size() != DEPTH || pop)) begin
        if (pop && q.size() != 0) void'(q.pop_front());
        q.push_back(wd);
      end else if (pop && q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    chk("count",        32'(count),        32'(q.size()));
    chk("empty",        32'(empty),        32'(q.size() == 0));
    chk("full",         32'(full),         32'(q.size() == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AEL));
    chk("almost_full",  32'(almost_full),  32'(q.size() >= AFL));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
    if (q.size() != 0) chk("read_data", 32'(read_data), 32'(q[0]));
  end

  // Apply inputs for one rising edge; returns 1 time unit after that edge
  task automatic drive(input logic p, input logic po, input logic [W-1:0] d);
    push = p;
    pop  = po;
    wd   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    wd    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset
    drive(1'b0, 1'b0, 8'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);

    // Fill with 0x01..0x0A
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 8));
      chk("fill_full", 32'(full), 32'(i == 10));
    end

    // Push with pop while full
    chk("full_head", 32'(read_data), 32'h01);
    drive(1'b1, 1'b1, 8'hAA);
    chk("fullpp_count", 32'(count), 32'd10);
    chk("fullpp_full", 32'(full), 32'd1);
    chk("fullpp_head", 32'(read_data), 32'h02);
    chk("fullpp_ovf", 32'(overflow), 32'd0);

    // Drain: 0x02..0x0A then 0xAA
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", 32'(read_data), (i < 9) ? 32'(i + 2) : 32'hAA);
      drive(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // Push with pop while empty
    drive(1'b1, 1'b1, 8'h55);
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_empty", 32'(empty), 32'd0);
    chk("emptypp_head", 32'(read_data), 32'h55);
    chk("emptypp_unf", 32'(underflow), ERR_EN ? 32'd1 : 32'd0);

    // Bring occupancy to 5, then 25 balanced pairs across the wrap
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'($urandom));
    chk("steady_start", 32'(count), 32'd5);
    for (int i = 0; i < 25; i++) drive(1'b1, 1'b1, 8'($urandom));
    chk("steady_end", 32'(count), 32'd5);

    // Reset in the middle of a burst at occupancy 6
    drive(1'b1, 1'b0, 8'h66);
    chk("pre_rst_count", 32'(count), 32'd6);
    push = 1'b1;
    wd   = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    push = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    chk("post_rst_empty", 32'(empty), 32'd1);
    drive(1'b0, 1'b1, 8'h00);
    chk("post_rst_count", 32'(count), 32'd0);

    // Random traffic with shifting push/pop bias
    for (int blk = 0; blk < 20; blk++) begin
      int pp = $urandom_range(10, 90);
      int pq = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++) begin
        drive($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq, 8'($urandom));
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
